// File: rtl/line_mem_ctrl.sv
// Line memory controller: a fixed-latency backing store of 256-bit lines.
// One request is outstanding at a time. The FSM walks IDLE -> WAIT -> ACK -> IDLE
// (IDLE -> ACK directly when LATENCY is 1), and the ACK cycle carries a one-cycle
// completion pulse with the read data or an out-of-range error.
//
// Timing: the request is latched at edge T0. The ACK state is entered LATENCY-1
// edges later, so ack_o is high in the cycle that ends at edge T0+LATENCY and is
// sampled high by the requester at that edge.
module line_mem_ctrl #(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 512,
    parameter int IDX_W   = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o,
    output logic         busy_o,
    output logic         err_o
);

    // Counter only has to hold LATENCY-2; keep it at least one bit wide.
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY >= 2) ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    logic [31:5]        r_line_q;
    logic [255:0]       r_data_q;
    logic               r_wr_q;
    logic [255:0]       r_data_o;
    logic [255:0]       r_mem [0:DEPTH-1];

    logic               w_enter_ack;
    logic [31:5]        w_req_line;
    logic [255:0]       w_req_data;
    logic               w_req_wr;
    logic [IDX_W-1:0]   w_req_idx;
    logic               w_req_in_range;
    logic               w_unused;

    // Byte offset within a line has no meaning to a line-granular memory.
    assign w_unused = ^addr_i[4:0];

    // The request being completed: straight from the ports when ACK is entered from
    // IDLE (LATENCY == 1), otherwise from the copy captured at acceptance.
    assign w_req_line     = (r_state == S_IDLE) ? addr_i[31:5] : r_line_q;
    assign w_req_data     = (r_state == S_IDLE) ? data_i       : r_data_q;
    assign w_req_wr       = (r_state == S_IDLE) ? write_i      : r_wr_q;
    assign w_req_idx      = w_req_line[IDX_W+4:5];
    assign w_req_in_range = (w_req_line[31:IDX_W+5] == '0);
    assign w_enter_ack    = (w_state_nxt == S_ACK);

    // Next-state and wait-counter logic.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches inferred.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (enable_i) begin
                    if (LATENCY == 1) begin
                        w_state_nxt = S_ACK;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_ACK;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_ACK:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, counter and registered read data; reset aborts any request in flight.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_data_o <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_data_o <= (w_enter_ack && !w_req_wr && w_req_in_range) ? r_mem[w_req_idx] : '0;
        end
    end

    // Capture the request on acceptance; these are only consumed while busy.
    always_ff @(posedge clk_i) begin
        if (r_state == S_IDLE && enable_i) begin
            r_line_q <= addr_i[31:5];
            r_data_q <= data_i;
            r_wr_q   <= write_i;
        end
    end

    // Commit an in-range write on the edge that enters ACK, unless reset drops it.
    always_ff @(posedge clk_i) begin
        // NOTE: the line array is deliberately not reset; contents survive rst_i.
        if (!rst_i && w_enter_ack && w_req_wr && w_req_in_range) begin
            r_mem[w_req_idx] <= w_req_data;
        end
    end

    assign ack_o  = (r_state == S_ACK);
    assign busy_o = (r_state != S_IDLE);
    assign err_o  = (r_state == S_ACK) && (r_line_q[31:IDX_W+5] != '0);
    assign data_o = r_data_o;

endmodule

// File: tb/tb_line_mem_ctrl.sv
// Testbench for line_mem_ctrl: a LATENCY=10 instance and a LATENCY=1 instance.
// Expected completions are queued when a request is driven and popped when the
// ack cycle is sampled. Outputs are sampled on the falling edge, i.e. the value
// the requester sees at the next rising edge; sample n after the accepting edge
// T0 is the value seen at edge T0+n, so ack is expected at n == LATENCY.
module tb_line_mem_ctrl;

    localparam int L0 = 10;
    localparam int L1 = 1;

    typedef struct {
        logic [255:0] data;
        logic         err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst0, en0, wr0, rst1, en1, wr1;
    logic [31:0]  addr0, addr1;
    logic [255:0] din0, din1;
    logic         ack0, busy0, err0, ack1, busy1, err1;
    logic [255:0] dout0, dout1;

    line_mem_ctrl #(.LATENCY(L0), .DEPTH(512), .IDX_W(9)) dut (
        .clk_i(clk), .rst_i(rst0), .enable_i(en0), .write_i(wr0), .addr_i(addr0),
        .data_i(din0), .ack_o(ack0), .data_o(dout0), .busy_o(busy0), .err_o(err0)
    );

    line_mem_ctrl #(.LATENCY(L1), .DEPTH(512), .IDX_W(9)) dut1 (
        .clk_i(clk), .rst_i(rst1), .enable_i(en1), .write_i(wr1), .addr_i(addr1),
        .data_i(din1), .ack_o(ack1), .data_o(dout1), .busy_o(busy1), .err_o(err1)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    int    sel     = 0;
    string cur     = "reset";
    exp_t  sb[$];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: observed %h expected %h", cur, tag, obs, exp);
        end
    endtask

    task automatic drive(input bit e, input bit w, input logic [31:0] a, input logic [255:0] d);
        if (sel == 0) begin
            en0 = e; wr0 = w; addr0 = a; din0 = d;
        end else begin
            en1 = e; wr1 = w; addr1 = a; din1 = d;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ack"},  (sel == 0) ? ack0  : ack1,  '0);
        check({tag, "_err"},  (sel == 0) ? err0  : err1,  '0);
        check({tag, "_busy"}, (sel == 0) ? busy0 : busy1, '0);
        check({tag, "_data"}, (sel == 0) ? dout0 : dout1, '0);
    endtask

    // Issue one request and follow it cycle by cycle through its completion.
    // hold: keep enable_i high through the ack cycle. b2b: drive at the current
    // falling edge (the cycle right after the previous ack) instead of waiting one.
    task automatic request(input bit w, input logic [31:0] a, input logic [255:0] d,
                           input logic [255:0] exp_data, input bit exp_err,
                           input bit hold, input bit b2b);
        exp_t e;
        int   lat;
        lat    = (sel == 0) ? L0 : L1;
        e.data = exp_data;
        e.err  = exp_err;
        sb.push_back(e);
        if (!b2b) @(negedge clk);
        drive(1'b1, w, a, d);
        @(posedge clk);
        for (int n = 1; n <= lat + 1; n++) begin
            @(negedge clk);
            if (n == lat) begin
                e = sb.pop_front();
                check("ack_pulse", (sel == 0) ? ack0  : ack1,  1'b1);
                check("ack_data",  (sel == 0) ? dout0 : dout1, e.data);
                check("ack_err",   (sel == 0) ? err0  : err1,  e.err);
                check("ack_busy",  (sel == 0) ? busy0 : busy1, 1'b1);
            end else begin
                check("no_ack",  (sel == 0) ? ack0  : ack1,  1'b0);
                check("no_err",  (sel == 0) ? err0  : err1,  1'b0);
                check("no_data", (sel == 0) ? dout0 : dout1, '0);
                check("busy",    (sel == 0) ? busy0 : busy1, (n <= lat) ? 1'b1 : 1'b0);
            end
            if ((!hold && n == 1) || (hold && n == lat + 1)) drive(1'b0, w, a, d);
        end
    endtask

    logic [255:0] pat_a5, pat_p, pat_q, pat_z, pat_x1, pat_x2;

    initial begin
        pat_a5 = {32{8'hA5}};
        pat_p  = {8{32'h1234_5678}};
        pat_q  = {8{32'hDEAD_BEEF}};
        pat_z  = {4{64'h0123_4567_89AB_CDEF}};
        pat_x1 = {8{32'h0F0F_3C3C}};
        pat_x2 = {8{32'h9999_6666}};

        rst0 = 1'b1; en0 = 1'b0; wr0 = 1'b0; addr0 = '0; din0 = '0;
        rst1 = 1'b1; en1 = 1'b0; wr1 = 1'b0; addr1 = '0; din1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst0 = 1'b0;
        rst1 = 1'b0;
        @(negedge clk);
        sel = 0; check_idle_outputs("rst0");
        sel = 1; check_idle_outputs("rst1");
        sel = 0;

        cur = "write_a5";
        request(1'b1, 32'h0000_0400, pat_a5, '0, 1'b0, 1'b0, 1'b0);

        cur = "read_a5_offset";
        request(1'b0, 32'h0000_041F, '0, pat_a5, 1'b0, 1'b0, 1'b0);

        cur = "hold_through_ack";
        request(1'b1, 32'h0000_0020, pat_p, '0, 1'b0, 1'b1, 1'b0);
        cur = "reraise_after_drop";
        request(1'b0, 32'h0000_0020, '0, pat_p, 1'b0, 1'b0, 1'b0);
        cur = "back_to_back";
        request(1'b0, 32'h0000_0400, '0, pat_a5, 1'b0, 1'b0, 1'b1);

        cur = "write_line0";
        request(1'b1, 32'h0000_0000, pat_z, '0, 1'b0, 1'b0, 1'b0);
        cur = "oor_read";
        request(1'b0, 32'h0000_4000, '0, '0, 1'b1, 1'b0, 1'b0);
        cur = "oor_write";
        request(1'b1, 32'h0000_4000, pat_q, '0, 1'b1, 1'b0, 1'b0);
        cur = "line0_intact";
        request(1'b0, 32'h0000_0000, '0, pat_z, 1'b0, 1'b0, 1'b0);

        // Abort a write to 0x20 with reset sampled at edge T0+5.
        cur = "reset_abort";
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h0000_0020, pat_q);
        @(posedge clk);
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            check("pre_rst_busy", busy0, 1'b1);
            check("pre_rst_ack",  ack0,  1'b0);
            if (n == 1) drive(1'b0, 1'b0, '0, '0);
        end
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        check_idle_outputs("post_rst");
        for (int n = 0; n < L0 + 3; n++) begin
            @(negedge clk);
            check("no_late_ack", ack0,  1'b0);
            check("no_late_busy", busy0, 1'b0);
        end
        cur = "read_after_abort";
        request(1'b0, 32'h0000_0020, '0, pat_p, 1'b0, 1'b0, 1'b0);

        // Single-cycle latency instance.
        sel = 1;
        cur = "l1_write1";
        request(1'b1, 32'h0000_0040, pat_x1, '0, 1'b0, 1'b0, 1'b0);
        cur = "l1_write2";
        request(1'b1, 32'h0000_3FE0, pat_x2, '0, 1'b0, 1'b0, 1'b1);
        cur = "l1_read1";
        request(1'b0, 32'h0000_0040, '0, pat_x1, 1'b0, 1'b0, 1'b1);
        cur = "l1_read2";
        request(1'b0, 32'h0000_3FFF, '0, pat_x2, 1'b0, 1'b0, 1'b1);
        cur = "l1_read1_again";
        request(1'b0, 32'h0000_0055, '0, pat_x1, 1'b0, 1'b0, 1'b1);
        cur = "l1_oor";
        request(1'b0, 32'h8000_0040, '0, '0, 1'b1, 1'b0, 1'b1);

        cur = "scoreboard";
        check("drained", 256'(sb.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
